// File: rtl/fmul_pipe.sv
// fmul_pipe: three-stage pipelined signed fixed-point multiplier.
//   S1 registers the product sign, the operand magnitudes and the rounding mode.
//   S2 registers the unsigned magnitude product.
//   S3 registers the scaled, rounded and range-fitted signed result.
// Optional feature: define FMUL_PIPE_SAT_EN to clamp out-of-range results to the
// most positive or most negative OUT_W value. Without it, the low OUT_W bits of
// the result are kept (wrap). In both builds out_ovf flags a result that did not fit.
//
// Handshake (valid/ready): a word moves across an interface only in a cycle where
// valid and ready are both high. out_data/out_ovf hold steady while
// out_valid & ~out_ready. All three stages shift together whenever S3 is empty or
// downstream is ready, and in_ready is exactly that advance condition.
module fmul_pipe #(
    parameter int A_W   = 17,
    parameter int B_W   = 8,
    parameter int FRAC  = 7,
    parameter int OUT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic             rnd_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int P  = A_W + B_W;         // magnitude product width
    localparam int RW = P + OUT_W + 2;     // working width of the signed result, wide enough to never clip

    logic             advance;

    logic             s1_valid;
    logic             s1_sign;
    logic             s1_rnd;
    logic [A_W-1:0]   s1_ma;
    logic [B_W-1:0]   s1_mb;

    logic             s2_valid;
    logic             s2_sign;
    logic             s2_rnd;
    logic [P-1:0]     s2_m;

    logic             s3_valid;
    logic [OUT_W-1:0] s3_data;
    logic             s3_ovf;

    logic [A_W-1:0]   a_mag;
    logic [B_W-1:0]   b_mag;

    logic [P:0]       half;
    logic [P:0]       sum;
    logic [RW-1:0]    q_ext;
    logic [RW-1:0]    r;
    logic [RW-OUT_W:0] upper;
    logic             fit;
    logic [OUT_W-1:0] res_data;
    logic             res_ovf;

    assign advance   = ~s3_valid | out_ready;
    assign in_ready  = advance;
    assign out_valid = s3_valid;
    assign out_data  = s3_data;
    assign out_ovf   = s3_ovf;

    // Operand magnitudes; the most negative value maps to 2^(W-1), which still fits unsigned in W bits.
    always_comb begin
        a_mag = in_a[A_W-1] ? -in_a : in_a;
        b_mag = in_b[B_W-1] ? -in_b : in_b;
    end

    // Scale the magnitude, optionally round half away from zero, reapply sign, then fit to OUT_W.
    always_comb begin
        half          = '0;
        half[FRAC-1]  = s2_rnd;
        sum           = {1'b0, s2_m} + half;
        q_ext         = RW'(sum >> FRAC);
        r             = s2_sign ? -q_ext : q_ext;
        // The result fits when every bit from OUT_W-1 upward equals the sign.
        upper         = r[RW-1:OUT_W-1];
        fit           = (upper == '0) || (upper == '1);
        res_ovf       = ~fit;
`ifdef FMUL_PIPE_SAT_EN
        if (fit) begin
            res_data = r[OUT_W-1:0];
        end else if (r[RW-1]) begin
            res_data = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            res_data = {1'b0, {(OUT_W-1){1'b1}}};
        end
`else
        res_data      = r[OUT_W-1:0];
`endif
    end

    // Stage 1: sign and magnitudes, captured whenever the pipeline advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_rnd   <= 1'b0;
            s1_ma    <= '0;
            s1_mb    <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_sign  <= in_a[A_W-1] ^ in_b[B_W-1];
            s1_rnd   <= rnd_mode;
            s1_ma    <= a_mag;
            s1_mb    <= b_mag;
        end
    end

    // Stage 2: unsigned magnitude product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_rnd   <= 1'b0;
            s2_m     <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_rnd   <= s1_rnd;
            s2_m     <= P'(s1_ma) * P'(s1_mb);
        end
    end

    // Stage 3: fitted result presented to downstream; held while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_data  <= '0;
            s3_ovf   <= 1'b0;
        end else if (advance) begin
            s3_valid <= s2_valid;
            s3_data  <= res_data;
            s3_ovf   <= res_ovf;
        end
    end

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: self-checking bench for fmul_pipe at default parameters.
// Expected results come from signed integer arithmetic on the operands; pipeline
// occupancy is tracked as three valid flags that shift on every advance.
module tb_fmul_pipe;

    localparam int A_W   = 17;
    localparam int B_W   = 8;
    localparam int FRAC  = 7;
    localparam int OUT_W = 17;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic             rnd_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [OUT_W:0] exp_q[$];       // {ovf, data} in acceptance order
    logic [2:0]     stage_v = '0;   // occupancy of the three stages

    logic             fired;
    logic [OUT_W-1:0] fired_data;
    logic             fired_ovf;
    logic             accepted;

    fmul_pipe #(.A_W(A_W), .B_W(B_W), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .rnd_mode(rnd_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Reference: exact signed product, symmetric rounding, then fit to OUT_W.
    function automatic logic [OUT_W:0] ref_mul(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                                input logic rnd);
        longint sa, sb, prod, mag, q, r, hi, lo;
        logic [OUT_W-1:0] d;
        logic ovf;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        prod = sa * sb;
        mag  = (prod < 0) ? -prod : prod;
        q    = (rnd ? mag + (longint'(1) << (FRAC - 1)) : mag) >> FRAC;
        r    = (prod < 0) ? -q : q;
        hi   = (longint'(1) << (OUT_W - 1)) - 1;
        lo   = -(longint'(1) << (OUT_W - 1));
        ovf  = (r > hi) || (r < lo);
        d    = OUT_W'(r);
`ifdef FMUL_PIPE_SAT_EN
        if (r > hi) d = OUT_W'(hi);
        if (r < lo) d = OUT_W'(lo);
`endif
        return {ovf, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, update the model, advance to posedge+1.
    task automatic cycle();
        logic adv;
        logic [OUT_W:0] e;
        @(negedge clk);
        adv      = !stage_v[2] || out_ready;
        fired    = 1'b0;
        accepted = 1'b0;
        check("in_ready", 32'(in_ready), 32'(adv));
        check("out_valid", 32'(out_valid), 32'(stage_v[2]));
        if (stage_v[2] && exp_q.size() > 0) begin
            e = exp_q[0];
            check("out_data", 32'(out_data), 32'(e[OUT_W-1:0]));
            check("out_ovf", 32'(out_ovf), 32'(e[OUT_W]));
            if (out_ready) begin
                fired      = 1'b1;
                fired_data = out_data;
                fired_ovf  = out_ovf;
                void'(exp_q.pop_front());
            end
        end
        if (adv) begin
            if (in_valid) begin
                exp_q.push_back(ref_mul(in_a, in_b, rnd_mode));
                accepted = 1'b1;
            end
            stage_v = {stage_v[1:0], in_valid};
        end
        @(posedge clk);
        #1;
    endtask

    // Send one operand into an empty pipeline and wait (bounded) for its result.
    task automatic single(input string tag, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                          input logic rnd, input logic [OUT_W-1:0] exp_d, input logic exp_o);
        int lat;
        logic [OUT_W-1:0] got_d;
        logic got_o;
        lat   = 0;
        got_d = '0;
        got_o = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        rnd_mode  = rnd;
        cycle();
        check({tag, "_accept"}, 32'(accepted), 32'(1));
        in_valid = 1'b0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            cycle();
            if (fired) begin
                lat   = k;
                got_d = fired_data;
                got_o = fired_ovf;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(3));
        check({tag, "_data"}, 32'(got_d), 32'(exp_d));
        check({tag, "_ovf"}, 32'(got_o), 32'(exp_o));
    endtask

    initial begin : stim
        int idx;
        int n_acc;
        int n_out;
        logic [OUT_W-1:0] outs [4];

        // Reset state.
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        rnd_mode = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_ovf", 32'(out_ovf), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_in_ready", 32'(in_ready), 32'(1));

        // Directed values.
        single("half",      17'h04000, 8'h40, 1'b0, 17'h02000, 1'b0);
        single("neg_half",  17'h1C000, 8'h40, 1'b0, 17'h1E000, 1'b0);
        single("zero_a",    17'h00000, 8'h80, 1'b0, 17'h00000, 1'b0);
        single("trunc_p3",  17'h00003, 8'h40, 1'b0, 17'h00001, 1'b0);
        single("round_p3",  17'h00003, 8'h40, 1'b1, 17'h00002, 1'b0);
        single("trunc_m3",  17'h1FFFD, 8'h40, 1'b0, 17'h1FFFF, 1'b0);
        single("round_m3",  17'h1FFFD, 8'h40, 1'b1, 17'h1FFFE, 1'b0);
`ifdef FMUL_PIPE_SAT_EN
        single("ovf_minmin", 17'h10000, 8'h80, 1'b0, 17'h0FFFF, 1'b1);
`else
        single("ovf_minmin", 17'h10000, 8'h80, 1'b0, 17'h10000, 1'b1);
`endif

        // Backpressure: with downstream stalled only three operands fit.
        out_ready = 1'b0;
        in_b = 8'h40;
        rnd_mode = 1'b0;
        idx = 1;
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_a = A_W'(idx * 2);
            cycle();
            if (accepted) begin
                n_acc++;
                idx++;
            end
        end
        check("stall_accepted", 32'(n_acc), 32'(3));
        check("stall_in_ready", 32'(in_ready), 32'(0));
        out_ready = 1'b1;
        n_out = 0;
        for (int k = 0; k < 12 && n_out < 4; k++) begin
            in_valid = (idx <= 4);
            in_a = A_W'(idx * 2);
            cycle();
            if (accepted) idx++;
            if (fired) begin
                outs[n_out] = fired_data;
                n_out++;
            end
        end
        in_valid = 1'b0;
        check("stall_out_count", 32'(n_out), 32'(4));
        for (int i = 0; i < 4; i++) begin
            check("stall_order", 32'(outs[i]), 32'(i + 1));
        end

        // Reset with two operands in flight.
        in_valid = 1'b1;
        in_a = 17'h00100;
        in_b = 8'h7F;
        cycle();
        in_a = 17'h1FF00;
        cycle();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_out_data", 32'(out_data), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        stage_v = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        single("after_rst", 17'h00200, 8'h40, 1'b0, 17'h00100, 1'b0);

        // Randomized traffic with random backpressure and boundary operands.
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rnd_mode  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: in_a = 17'h10000;
                1: in_a = 17'h0FFFF;
                2: in_a = 17'h00000;
                default: in_a = A_W'($urandom());
            endcase
            case ($urandom_range(0, 5))
                0: in_b = 8'h80;
                1: in_b = 8'h7F;
                2: in_b = 8'h00;
                default: in_b = B_W'($urandom());
            endcase
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        check("drain_empty", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fmul_pipe.md
FMUL_PIPE -- requirements
Module: fmul_pipe

Interface
REQ-001 Parameter A_W, default 17: width of signed two's-complement operand a.
REQ-002 Parameter B_W, default 8: width of signed two's-complement operand b (coefficient).
REQ-003 Parameter FRAC, default 7: number of product fraction bits discarded (FRAC >= 1, FRAC < A_W+B_W).
REQ-004 Parameter OUT_W, default 17: width of signed two's-complement result.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  operand pair present.
REQ-008 in_ready  output  1  block accepts operands this cycle.
REQ-009 in_a  input  A_W  signed operand a.
REQ-010 in_b  input  B_W  signed operand b.
REQ-011 rnd_mode  input  1  0 = truncate toward zero, 1 = round half away from zero; sampled with operands.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_data  output  OUT_W  signed scaled product.
REQ-015 out_ovf  output  1  result did not fit OUT_W; qualified by out_valid.

Function
REQ-016 Transfer occurs on in_valid & in_ready (input) and out_valid & out_ready (output).
REQ-017 Three register stages S1 (sign, magnitudes, rnd_mode), S2 (unsigned magnitude product), S3 (scaled, rounded, fitted result); each holds a valid bit.
REQ-018 Global advance = ~S3.valid | out_ready; all stages shift together on advance, hold otherwise; in_ready = advance (combinational).
REQ-019 Latency 3 cycles from accept to out_valid with no stall; throughput one result per cycle; results leave in acceptance order, none dropped or duplicated.
REQ-020 Sign = a[A_W-1] XOR b[B_W-1]; magnitudes are |a| (A_W+1... stored A_W bits unsigned, -2^(A_W-1) representable) and |b| likewise; product magnitude M is A_W+B_W bits.
REQ-021 Truncate: Q = M >> FRAC; round: Q = (M + 2^(FRAC-1)) >> FRAC; result R = sign ? -Q : Q (rounding symmetric about zero).
REQ-022 Fit: if R in [-2^(OUT_W-1), 2^(OUT_W-1)-1], out_data = R, out_ovf = 0; else behaviour per REQ-030/031 with out_ovf = 1.
REQ-023 Zero operand gives out_data = 0, out_ovf = 0, sign ignored (no negative zero issue).
REQ-024 out_data and out_ovf hold stable while out_valid & ~out_ready.
REQ-025 in_a/in_b/rnd_mode are don't-care when in_valid = 0; bubbles propagate as invalid stages.

Reset
REQ-026 While rst = 1, all stage valid bits clear immediately (asynchronously); out_valid = 0, out_data = 0, out_ovf = 0.
REQ-027 in_ready = 1 during and immediately after reset (pipeline empty).
REQ-028 Reset mid-operation discards all in-flight operands; no result from before reset ever appears.
REQ-029 First acceptance after rst deasserts yields out_valid exactly 3 cycles later with out_ready = 1.

Configuration
REQ-030 Macro FMUL_PIPE_SAT_EN defined: out-of-range R clamps to 2^(OUT_W-1)-1 (positive) or -2^(OUT_W-1) (negative), out_ovf = 1.
REQ-031 Macro FMUL_PIPE_SAT_EN undefined: out_data = low OUT_W bits of R (wrap), out_ovf = 1 when discarded bits differ from R's sign; no clamp logic synthesised.

Verification (defaults A_W=17, B_W=8, FRAC=7, OUT_W=17)
REQ-032 a=0x04000, b=0x40, rnd=0 -> out_data 0x02000, ovf 0, exactly 3 cycles after accept.
REQ-033 a=0x1C000 (-16384), b=0x40 -> 0x1E000 (-8192), ovf 0; a=0, b=0x80 -> 0x00000.
REQ-034 a=3, b=0x40: rnd=0 -> 0x00001, rnd=1 -> 0x00002; a=0x1FFFD (-3), b=0x40: rnd=0 -> 0x1FFFF, rnd=1 -> 0x1FFFE.
REQ-035 a=0x10000, b=0x80: SAT_EN -> 0x0FFFF, ovf 1; without -> 0x10000, ovf 1.
REQ-036 out_ready=0, in_valid=1 continuous with values 1..4 -> exactly 3 accepted then in_ready=0; out_ready=1 -> results 1,2,3 then 4 in order, no loss.
REQ-037 rst pulsed with 2 operands in flight -> out_valid stays 0, no stale result after release; next operand returns after 3 cycles.
